// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its burst reader:
// default widths, reader state encodings and a skid-buffer occupancy helper.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    FBR_IDLE = 2'd0,
    FBR_READ = 2'd1,
    FBR_DONE = 2'd2
  } fbr_state_e;

  // Skid-buffer occupancy once this cycle's push and pop have landed.
  function automatic logic [1:0] fbr_next_occ(input logic [1:0] occ,
                                              input logic       push,
                                              input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer of {last, data} words between the FIFO read port and the stream.
// Flush drops every buffered word; the head entry is always visible on head_data_o.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       occupancy_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;

  // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= fbr_next_occ(cnt_q, push_i, pop_i);
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign occupancy_o = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: on start, pops exactly burst_len words from the synchronous FIFO and streams them
// with a last marker. Macro FIFO_BURST_READER_TIMEOUT_EN adds an empty-FIFO timeout (err_timeout).
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = FIFO_DATA_WIDTH,
  parameter int LEN_WIDTH      = FIFO_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_en_read,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err_timeout
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  fbr_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic [1:0]           occ_s;
  logic [DATA_WIDTH:0]  head_s;
  logic                 pop_s;
  logic                 slot_free_s;
  logic                 rd_en_s;
  logic                 flush_s;
  logic                 timeout_hit_s;

  assign pop_s       = m_valid && m_ready;
  assign slot_free_s = (fbr_next_occ(occ_s, inflight_q, pop_s) < 2'd2);

  // Next-state and read-issue decode; completion takes priority over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    rd_en_s     = 1'b0;
    flush_s     = 1'b0;
    case (state_q)
      FBR_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d     = FBR_READ;
            issue_cnt_d = burst_len;
            beat_cnt_d  = burst_len;
          end else begin
            state_d = FBR_DONE;
          end
        end else begin
          state_d = FBR_IDLE;
        end
      end
      FBR_READ: begin
        rd_en_s = !fifo_empty && (issue_cnt_q != '0) && slot_free_s;
        if (rd_en_s) begin
          issue_cnt_d = issue_cnt_q - LEN_ONE;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (pop_s && (beat_cnt_q != '0)) begin
          beat_cnt_d = beat_cnt_q - LEN_ONE;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        if (pop_s && (beat_cnt_q == LEN_ONE)) begin
          state_d = FBR_DONE;
        end else if (timeout_hit_s) begin
          state_d = FBR_DONE;
          flush_s = 1'b1;
        end else begin
          state_d = FBR_READ;
        end
      end
      FBR_DONE: state_d = FBR_IDLE;
      default:  state_d = FBR_IDLE;
    endcase
  end

  // State, counters and the one-deep record of the read issued last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= FBR_IDLE;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_cnt_q     <= issue_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      inflight_q      <= rd_en_s;
      inflight_last_q <= rd_en_s && (issue_cnt_q == LEN_ONE);
    end
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int                 TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            empty_wait_s;

  assign empty_wait_s  = (state_q == FBR_READ) && fifo_empty && (issue_cnt_q != '0);
  assign timeout_hit_s = empty_wait_s && (to_cnt_q == TO_LAST);

  // Consecutive-empty counter and sticky error, cleared by the next accepted start.
  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q;
    if (empty_wait_s && !timeout_hit_s) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_d = '0;
    end
    if ((state_q == FBR_IDLE) && start) begin
      err_d = 1'b0;
    end else if (timeout_hit_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit_s = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  // A flush also discards the word arriving from the FIFO this cycle.
  fifo_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_s),
    .push_i      (inflight_q && !flush_s),
    .push_data_i ({inflight_last_q, fifo_data_out}),
    .pop_i       (pop_s),
    .head_data_o (head_s),
    .occupancy_o (occ_s)
  );

  assign m_valid      = (occ_s != 2'd0);
  assign m_data       = head_s[DATA_WIDTH-1:0];
  assign m_last       = m_valid && head_s[DATA_WIDTH];
  assign busy         = (state_q == FBR_READ);
  assign done         = (state_q == FBR_DONE);
  assign fifo_en_read = rd_en_s;

endmodule
